// File: rtl/mem_stage.sv
// Memory-access stage: issues data-SRAM loads/stores over an addr_ok/data_ok handshake and builds the MEM->WB bus.
// Optional build macro MEM_MISALIGN_CHK_EN: misaligned half/word accesses skip the SRAM and complete flagged on mem_ale_o.
`ifndef MEM2WBBusSize
`define MEM2WBBusSize 102
`endif

module mem_stage #(
  parameter int DM_ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [106:0]              exe2mem_bus_ri,
  input  logic                      ctl_mem_valid_i,
  output logic                      ctl_mem_over_o,
  output logic [4:0]                ctl_mem_dest_o,
  output logic [`MEM2WBBusSize-1:0] mem2wb_bus_o,
  output logic                      dm_req_o,
  output logic                      dm_we_o,
  output logic [3:0]                dm_wstrb_o,
  output logic [DM_ADDR_W-1:0]      dm_addr_o,
  output logic [31:0]               dm_wdata_o,
  input  logic                      dm_addr_ok_i,
  input  logic                      dm_data_ok_i,
  input  logic [31:0]               dm_rdata_i
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic                      mem_ale_o
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t      state, state_nxt;
  logic        drain_p1;
  logic [31:0] ld_data_p1;
  logic        ale_p1;

  logic        mem_re, mem_we, mem_sext, we;
  logic [1:0]  mem_size;
  logic [31:0] store_data, alu_result, pc;
  logic [4:0]  wdest;
  logic        mem_op, misalign;
  logic [1:0]  a;

  assign {mem_re, mem_we, mem_size, mem_sext, store_data, alu_result, wdest, we, pc} = exe2mem_bus_ri;
  assign mem_op = mem_re | mem_we;
  assign a      = alu_result[1:0];

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      2'b00:   return 4'b0001 << addr;
      2'b01:   return 4'b0011 << {addr[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] sd);
    case (size)
      2'b00:   return {4{sd[7:0]}};
      2'b01:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [1:0] addr,
                                             input logic [1:0] size, input logic sext);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    sh = rdata >> {addr, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00: begin
        ext = b;
        if (!sext) ext[31:8] = '0;
      end
      2'b01: begin
        ext = h;
        if (!sext) ext[31:16] = '0;
      end
      default: ext = sh;
    endcase
    return ext;
  endfunction

`ifdef MEM_MISALIGN_CHK_EN
  assign misalign = ((mem_size == 2'b01) && a[0]) || (mem_size[1] && (a != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ctl_mem_valid_i && mem_op) begin
          if (misalign)          state_nxt = DONE;
          else if (dm_addr_ok_i) state_nxt = WAIT;
          else                   state_nxt = REQ;
        end
      end
      REQ: begin
        if (!ctl_mem_valid_i)  state_nxt = IDLE;
        else if (dm_addr_ok_i) state_nxt = WAIT;
      end
      // A flushed instruction still owns the outstanding response; swallow it without completing.
      WAIT: begin
        if (dm_data_ok_i) state_nxt = (drain_p1 || !ctl_mem_valid_i) ? IDLE : DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ctl_mem_over_o = 1'b0;
    dm_req_o       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          ctl_mem_over_o = ctl_mem_valid_i && !mem_op;
          dm_req_o       = ctl_mem_valid_i && mem_op && !misalign;
        end
        REQ:     dm_req_o       = ctl_mem_valid_i;
        DONE:    ctl_mem_over_o = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_p1   <= 1'b0;
      ld_data_p1 <= '0;
      ale_p1     <= 1'b0;
    end else begin
      drain_p1 <= (state == WAIT) && (drain_p1 || !ctl_mem_valid_i) && !dm_data_ok_i;
      if ((state == WAIT) && (state_nxt == DONE))
        ld_data_p1 <= load_align(dm_rdata_i, a, mem_size, mem_sext);
      ale_p1 <= (state == IDLE) && (state_nxt == DONE);
    end
  end

  assign dm_we_o    = mem_we;
  assign dm_wstrb_o = store_strb(mem_size, a);
  assign dm_wdata_o = store_align(mem_size, store_data);
  assign dm_addr_o  = alu_result[DM_ADDR_W-1:0];

  logic        wb_we;
  logic [31:0] wb_result, wb_dbg_addr;

`ifdef MEM_MISALIGN_CHK_EN
  assign mem_ale_o = (state == DONE) && ale_p1 && !rst;
  assign wb_we     = we && ctl_mem_valid_i && !((state == DONE) && ale_p1);
`else
  assign wb_we     = we && ctl_mem_valid_i;
`endif

  assign wb_result      = mem_re ? ld_data_p1 : alu_result;
  assign wb_dbg_addr    = mem_op ? alu_result : 32'd0;
  assign mem2wb_bus_o   = {wdest, wb_we, wb_result, wb_dbg_addr, pc};
  assign ctl_mem_dest_o = wdest & {5{ctl_mem_valid_i}};

endmodule
